blur_frame_sched: RTL and testbench
===================================

// Module: blur_frame_sched
// PURPOSE
//  Frame-level sequencer for the Gaussian blur engine. Takes one host frame request and runs the engine through a whole image:
//  - latches sigma, starts kernel generation, then pulses the new-transfer strobe;
//  - writes every blurred pixel to the output image buffer, at an address that follows the engine's serpentine scan;
//  - reports done/error upstream.
//  Sits between the ISP top-level control and the blur engine, ahead of the FAST corner stage.
// PARAMETERS
//  OUT_W        200  output pixels per row (x range 0..OUT_W-1)
//  OUT_H        200  output rows (y range 0..OUT_H-1)
//  KERNEL_LAT   16   cycles to wait after start_conv before new_trans (kernel build time)
//  TIMEOUT      1024 max cycles in RUN between blur_complete pulses before error
// PORTS
//  clk            in   1   system clock
//  n_rst          in   1   async active-low reset
//  frame_start    in   1   host request, 1-cycle pulse; ignored unless IDLE/ERR
//  abort          in   1   level; forces return to IDLE from any state
//  sigma_in       in   3   blur strength, sampled on accepted frame_start
//  busy           out  1   high in KERNEL, TRANS, RUN
//  frame_done     out  1   1-cycle pulse on a successful frame end
//  frame_err      out  1   sticky error flag, cleared by accepted frame_start or abort
//  sigma          out  3   to engine; registered copy of sigma_in
//  start_conv     out  1   to engine, 1-cycle pulse
//  new_trans      out  1   to engine, 1-cycle pulse
//  conv_err       in   1   engine kernel error
//  blur_complete  in   1   engine per-pixel done strobe
//  conv_done      in   1   engine last-pixel strobe (coincides with final blur_complete)
//  blurred_pixel  in   8   engine output pixel, valid with blur_complete
//  wen_out        out  1   output buffer write enable
//  wdat_out       out  8   output buffer write data
//  x_addr_out     out  $clog2(OUT_W)  output buffer column address
//  y_addr_out     out  $clog2(OUT_H)  output buffer row address
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; internal x, y, pix_cnt, wdog = 0.
//  FSM:
//   IDLE   -frame_start-> KERNEL: latch sigma; pulse start_conv in the cycle after frame_start; clear frame_err; zero x/y/pix_cnt.
//   KERNEL: count KERNEL_LAT cycles.
//     - conv_err seen -> ERR.
//     - count expires -> TRANS.
//   TRANS: pulse new_trans for exactly 1 cycle -> RUN.
//   RUN, on blur_complete:
//     - next cycle: wen_out=1, wdat_out=blurred_pixel, address = current x,y (1-cycle write latency); then advance the address;
//     - pix_cnt++; wdog is reset.
//   RUN, otherwise wdog++; wdog==TIMEOUT-1 -> ERR.
//   RUN, conv_done (with its blur_complete): write the final pixel, then
//     - pix_cnt+1 == OUT_W*OUT_H -> DONE;
//     - otherwise -> ERR (count mismatch).
//   DONE: frame_done=1 for 1 cycle -> IDLE.
//   ERR: frame_err=1, held; frame_start -> KERNEL (same as from IDLE).
//  Address walk (serpentine):
//   - even y: x increments; odd y: x decrements;
//   - at the row end (x==OUT_W-1 even / x==0 odd), x holds and y increments;
//   - y never wraps; a blur_complete after the last pixel without conv_done -> ERR.
//  pix_cnt width: $clog2(OUT_W*OUT_H+1).
//  Simultaneous events:
//   - abort beats all; next cycle IDLE, outputs 0, frame_err cleared;
//   - frame_start in busy states is dropped;
//   - blur_complete outside RUN is ignored, no write;
//   - conv_err in RUN -> ERR.
//  Reset mid-frame: async return to reset values; no partial write completes.
// CONFIGURATION
//  BLUR_SCHED_PERF_EN defined:
//   - adds output perf_cycles[31:0]: RUN-state cycles of the last frame;
//   - adds output perf_stalls[31:0]: RUN cycles with no blur_complete;
//   - both cleared on accepted frame_start, frozen at DONE/ERR.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package blur_sched_pkg:
//   - typedef enum logic [2:0] sched_state_t {IDLE, KERNEL, TRANS, RUN, DONE, ERR};
//   - localparam default sizes.
//  One sub-module, serp_addr_gen: x/y serpentine counter with inc/clear/last outputs.
//  Everything else lives in the top FSM.
// TESTING
//  1 OUT_W=4,OUT_H=3, sigma_in=2, 12 blur_complete (last with conv_done), pixel=addr index -> sigma=2, one start_conv, one new_trans, writes (0,0)..(3,0),(3,1)..(0,1),(0,2)..(3,2), frame_done once.
//  2 conv_err high 3 cycles into KERNEL -> ERR, frame_err=1, no new_trans, no writes.
//  3 TIMEOUT=8, no blur_complete after TRANS -> frame_err=1 exactly 8 cycles into RUN.
//  4 conv_done on 10th pixel of 12 -> ERR, frame_done never asserted.
//  5 abort mid-RUN after 5 pixels, then frame_start -> IDLE, next frame restarts at (0,0), pix_cnt=0.
//  6 frame_start during RUN, and blur_complete in IDLE -> both ignored; no state change; wen_out stays 0.

Source files
------------

// File: rtl/blur_sched_pkg.sv
// Shared types and default geometry/timing for the blur frame scheduler.
package blur_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KERNEL = 3'd1,
        TRANS  = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } sched_state_t;

    localparam int DEF_OUT_W      = 200;
    localparam int DEF_OUT_H      = 200;
    localparam int DEF_KERNEL_LAT = 16;
    localparam int DEF_TIMEOUT    = 1024;

endpackage

// File: rtl/blur_frame_sched_if.sv
// Host, blur-engine and output-buffer signals of the frame scheduler.
// Optional perf counters appear only when BLUR_SCHED_PERF_EN is defined.
interface blur_frame_sched_if
    import blur_sched_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int OUT_H = DEF_OUT_H
) ();
    localparam int XW = $clog2(OUT_W);
    localparam int YW = $clog2(OUT_H);

    logic          frame_start;
    logic          abort;
    logic [2:0]    sigma_in;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic [2:0]    sigma;
    logic          start_conv;
    logic          new_trans;
    logic          conv_err;
    logic          blur_complete;
    logic          conv_done;
    logic [7:0]    blurred_pixel;
    logic          wen_out;
    logic [7:0]    wdat_out;
    logic [XW-1:0] x_addr_out;
    logic [YW-1:0] y_addr_out;
`ifdef BLUR_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_stalls;
`endif

    modport master (
        input  frame_start, abort, sigma_in, conv_err, blur_complete, conv_done, blurred_pixel,
        output busy, frame_done, frame_err, sigma, start_conv, new_trans,
               wen_out, wdat_out, x_addr_out, y_addr_out
`ifdef BLUR_SCHED_PERF_EN
        , output perf_cycles, perf_stalls
`endif
    );

    modport slave (
        output frame_start, abort, sigma_in, conv_err, blur_complete, conv_done, blurred_pixel,
        input  busy, frame_done, frame_err, sigma, start_conv, new_trans,
               wen_out, wdat_out, x_addr_out, y_addr_out
`ifdef BLUR_SCHED_PERF_EN
        , input perf_cycles, perf_stalls
`endif
    );

endinterface

// File: rtl/serp_addr_gen.sv
// Serpentine x/y walker: even rows run left-to-right, odd rows right-to-left.
// Advances one position per i_inc; holds at the final pixel, never wraps.
module serp_addr_gen #(
    parameter int OUT_W = 200,
    parameter int OUT_H = 200
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_clr,
    input  logic                     i_inc,
    output logic [$clog2(OUT_W)-1:0] o_x,
    output logic [$clog2(OUT_H)-1:0] o_y,
    output logic                     o_last
);
    localparam int XW = $clog2(OUT_W);
    localparam int YW = $clog2(OUT_H);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_odd;
    logic          w_row_end;
    logic          w_last_row;

    assign w_odd      = r_y[0];
    assign w_row_end  = w_odd ? (r_x == '0) : (r_x == XW'(OUT_W - 1));
    assign w_last_row = (r_y == YW'(OUT_H - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_inc) begin
            // Turning a row keeps x in place so the next row starts where this one ended.
            if (w_row_end) begin
                if (!w_last_row)
                    r_y <= r_y + YW'(1);
            end else if (w_odd) begin
                r_x <= r_x - XW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_row_end && w_last_row;

endmodule

// File: rtl/blur_frame_sched.sv
// Frame sequencer for the blur engine: kernel build, transfer kick-off, serpentine output writes.
// Pixel writes land one cycle after blur_complete; BLUR_SCHED_PERF_EN adds RUN perf counters.
module blur_frame_sched
    import blur_sched_pkg::*;
#(
    parameter int OUT_W      = DEF_OUT_W,
    parameter int OUT_H      = DEF_OUT_H,
    parameter int KERNEL_LAT = DEF_KERNEL_LAT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input logic                clk,
    input logic                n_rst,
    blur_frame_sched_if.master bus
);
    localparam int TOTAL = OUT_W * OUT_H;
    localparam int PIX_W = $clog2(TOTAL + 1);
    localparam int KW    = $clog2(KERNEL_LAT + 1);
    localparam int WDW   = $clog2(TIMEOUT + 1);
    localparam int XW    = $clog2(OUT_W);
    localparam int YW    = $clog2(OUT_H);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [KW-1:0]    r_kcnt;
    logic [WDW-1:0]   r_wdog;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [2:0]       r_sigma;
    logic             r_wen;
    logic [7:0]       r_wdat;
    logic [XW-1:0]    r_x_out;
    logic [YW-1:0]    r_y_out;
    logic [XW-1:0]    w_x;
    logic [YW-1:0]    w_y;
    logic             w_addr_last;
    logic             w_accept;
    logic             w_wr;
    logic             w_clr;
    logic             w_overrun;
    logic             w_last_pix;
    logic             w_busy;
    logic             w_frame_done;
    logic             w_frame_err;
    logic             w_start_conv;
    logic             w_new_trans;

    serp_addr_gen #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H)
    ) u_addr (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_clr  (w_clr),
        .i_inc  (w_wr),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_addr_last)
    );

    assign w_clr      = w_accept | bus.abort;
    // Every pixel already written and the walker parked on the last one.
    assign w_overrun  = w_addr_last && (r_pix_cnt == PIX_W'(TOTAL));
    assign w_last_pix = ((r_pix_cnt + PIX_W'(1)) == PIX_W'(TOTAL));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_wr         = 1'b0;
        w_busy       = 1'b0;
        w_frame_done = 1'b0;
        w_frame_err  = 1'b0;
        w_start_conv = 1'b0;
        w_new_trans  = 1'b0;

        case (r_state)
            KERNEL: begin
                w_busy       = 1'b1;
                w_start_conv = (r_kcnt == '0);
            end
            TRANS: begin
                w_busy      = 1'b1;
                w_new_trans = 1'b1;
            end
            RUN:     w_busy       = 1'b1;
            DONE:    w_frame_done = 1'b1;
            ERR:     w_frame_err  = 1'b1;
            default: ;
        endcase

        if (bus.abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, ERR: begin
                    if (bus.frame_start) begin
                        w_state_nxt = KERNEL;
                        w_accept    = 1'b1;
                    end
                end
                KERNEL: begin
                    if (bus.conv_err)
                        w_state_nxt = ERR;
                    else if (r_kcnt == KW'(KERNEL_LAT - 1))
                        w_state_nxt = TRANS;
                end
                TRANS: w_state_nxt = RUN;
                RUN: begin
                    if (bus.conv_err) begin
                        w_state_nxt = ERR;
                    end else if (bus.blur_complete) begin
                        if (w_overrun) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_wr = 1'b1;
                            if (bus.conv_done)
                                w_state_nxt = w_last_pix ? DONE : ERR;
                        end
                    end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                        w_state_nxt = ERR;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_kcnt    <= '0;
            r_wdog    <= '0;
            r_pix_cnt <= '0;
            r_sigma   <= '0;
            r_wen     <= 1'b0;
            r_wdat    <= '0;
            r_x_out   <= '0;
            r_y_out   <= '0;
        end else begin
            r_wen <= w_wr;
            if (w_wr) begin
                r_wdat  <= bus.blurred_pixel;
                r_x_out <= w_x;
                r_y_out <= w_y;
            end
            if (w_accept) begin
                r_sigma   <= bus.sigma_in;
                r_kcnt    <= '0;
                r_wdog    <= '0;
                r_pix_cnt <= '0;
            end else begin
                if (r_state == KERNEL)
                    r_kcnt <= r_kcnt + KW'(1);
                if (r_state == RUN)
                    r_wdog <= bus.blur_complete ? '0 : r_wdog + WDW'(1);
                if (w_wr)
                    r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end
            // Abort drops the in-flight write and returns every output to zero.
            if (bus.abort) begin
                r_sigma   <= '0;
                r_wdat    <= '0;
                r_x_out   <= '0;
                r_y_out   <= '0;
                r_pix_cnt <= '0;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.frame_done = w_frame_done;
    assign bus.frame_err  = w_frame_err;
    assign bus.start_conv = w_start_conv;
    assign bus.new_trans  = w_new_trans;
    assign bus.sigma      = r_sigma;
    assign bus.wen_out    = r_wen;
    assign bus.wdat_out   = r_wdat;
    assign bus.x_addr_out = r_x_out;
    assign bus.y_addr_out = r_y_out;

`ifdef BLUR_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state == RUN) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
            if (!bus.blur_complete)
                r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign bus.perf_cycles = r_perf_cycles;
    assign bus.perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_blur_frame_sched.sv
// Directed-plus-random bench for blur_frame_sched on a 4x3 image with an 8-cycle watchdog.
module tb_blur_frame_sched;
    localparam int W     = 4;
    localparam int H     = 3;
    localparam int KL    = 16;
    localparam int TO    = 8;
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    logic n_rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    blur_frame_sched_if #(.OUT_W(W), .OUT_H(H)) bus ();

    blur_frame_sched #(
        .OUT_W      (W),
        .OUT_H      (H),
        .KERNEL_LAT (KL),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Observed activity, recorded away from the active edge.
    int obs_w[256];
    int obs_n = 0;
    int n_sc  = 0;
    int n_nt  = 0;
    int n_fd  = 0;

    always @(negedge clk) begin
        if (bus.wen_out === 1'b1 && obs_n < 256) begin
            obs_w[obs_n] = int'(bus.y_addr_out) * 65536 + int'(bus.x_addr_out) * 256 + int'(bus.wdat_out);
            obs_n++;
        end
        if (bus.start_conv === 1'b1) n_sc++;
        if (bus.new_trans === 1'b1)  n_nt++;
        if (bus.frame_done === 1'b1) n_fd++;
    end

    // Reference: expected writes of the current frame, derived from pixel index.
    int exp_w[64];
    int exp_n;
    int base_w, base_sc, base_nt, base_fd;

    function automatic int model_write(input int k, input int d);
        int x, y;
        y = k / W;
        x = (y % 2 == 0) ? (k % W) : (W - 1 - (k % W));
        return y * 65536 + x * 256 + d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        base_w  = obs_n;
        base_sc = n_sc;
        base_nt = n_nt;
        base_fd = n_fd;
        exp_n   = 0;
    endtask

    task automatic begin_frame(input logic [2:0] sig);
        int c;
        snap();
        bus.sigma_in    = sig;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("start_conv", bus.start_conv, 1);
        chk("sigma_latch", bus.sigma, sig);
        chk("err_cleared", bus.frame_err, 0);
        c = 0;
        while (bus.new_trans !== 1'b1 && c < 60) begin
            tick();
            c++;
        end
        chk("kernel_lat", c, KL);
        tick();
        chk("run_busy", bus.busy, 1);
    endtask

    task automatic feed(input int k0, input int n, input int cd_idx, input bit rnd);
        int g, d;
        for (int k = k0; k < k0 + n; k++) begin
            g = $urandom_range(0, 3);
            repeat (g) tick();
            d = rnd ? $urandom_range(0, 255) : k;
            bus.blurred_pixel = 8'(d);
            bus.blur_complete = 1'b1;
            bus.conv_done     = (k == cd_idx);
            if (k < TOTAL) begin
                exp_w[exp_n] = model_write(k, d);
                exp_n++;
            end
            tick();
            bus.blur_complete = 1'b0;
            bus.conv_done     = 1'b0;
        end
    endtask

    task automatic compare_writes();
        chk("write_count", obs_n - base_w, exp_n);
        for (int i = 0; i < exp_n && base_w + i < obs_n; i++)
            chk($sformatf("write%0d", i), obs_w[base_w + i], exp_w[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [2:0] sig;
        bus.frame_start   = 1'b0;
        bus.abort         = 1'b0;
        bus.sigma_in      = '0;
        bus.conv_err      = 1'b0;
        bus.blur_complete = 1'b0;
        bus.conv_done     = 1'b0;
        bus.blurred_pixel = '0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        repeat (3) tick();
        chk("rst_flags", {bus.busy, bus.frame_done, bus.frame_err, bus.start_conv, bus.new_trans}, 0);
        chk("rst_wen", bus.wen_out, 0);
        chk("rst_sigma", bus.sigma, 0);
        chk("rst_wbus", {bus.wdat_out, bus.x_addr_out, bus.y_addr_out}, 0);
        n_rst = 1'b1;
        tick();

        // Full frame, pixel value = scan index.
        begin_frame(3'd2);
        feed(0, TOTAL, TOTAL - 1, 1'b0);
        chk("t1_done_pulse", bus.frame_done, 1);
        tick();
        chk("t1_done_clear", bus.frame_done, 0);
        compare_writes();
        chk("t1_start_conv_n", n_sc - base_sc, 1);
        chk("t1_new_trans_n", n_nt - base_nt, 1);
        chk("t1_frame_done_n", n_fd - base_fd, 1);
        chk("t1_sigma", bus.sigma, 2);

        // Random frame with a frame_start dropped mid-RUN.
        sig = 3'($urandom_range(0, 7));
        begin_frame(sig);
        feed(0, 4, -1, 1'b1);
        bus.sigma_in    = ~sig;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("t6_fs_busy", bus.busy, 1);
        chk("t6_fs_sigma", bus.sigma, sig);
        feed(4, TOTAL - 4, TOTAL - 1, 1'b1);
        chk("t6_done_pulse", bus.frame_done, 1);
        tick();
        compare_writes();
        chk("t6_start_conv_n", n_sc - base_sc, 1);

        // blur_complete while IDLE writes nothing.
        snap();
        bus.blurred_pixel = 8'h55;
        bus.blur_complete = 1'b1;
        repeat (3) tick();
        bus.blur_complete = 1'b0;
        tick();
        chk("t6_idle_writes", obs_n - base_w, 0);
        chk("t6_idle_busy", bus.busy, 0);

        // conv_err during kernel build.
        snap();
        bus.sigma_in    = 3'd1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (3) tick();
        bus.conv_err = 1'b1;
        tick();
        bus.conv_err = 1'b0;
        chk("t2_err", bus.frame_err, 1);
        chk("t2_busy", bus.busy, 0);
        repeat (5) tick();
        chk("t2_err_sticky", bus.frame_err, 1);
        chk("t2_new_trans_n", n_nt - base_nt, 0);
        chk("t2_writes", obs_n - base_w, 0);

        // Watchdog: restart from ERR, then starve RUN.
        begin_frame(3'd5);
        begin
            int c;
            c = 0;
            while (bus.frame_err !== 1'b1 && c < 40) begin
                tick();
                c++;
            end
            chk("t3_wdog_cycles", c, TO);
        end

        // Early conv_done on the 10th pixel.
        begin_frame(3'd1);
        feed(0, 10, 9, 1'b1);
        chk("t4_err", bus.frame_err, 1);
        tick();
        compare_writes();
        chk("t4_no_done", n_fd - base_fd, 0);

        // Abort after 5 pixels, then a clean frame from (0,0).
        begin_frame(3'd3);
        feed(0, 5, -1, 1'b1);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_abort_flags", {bus.busy, bus.frame_err, bus.frame_done, bus.wen_out}, 0);
        chk("t5_abort_sigma", bus.sigma, 0);
        tick();
        compare_writes();
        begin_frame(3'd4);
        feed(0, TOTAL, TOTAL - 1, 1'b1);
        chk("t5_done_pulse", bus.frame_done, 1);
        tick();
        compare_writes();

        // Extra blur_complete past the last pixel without conv_done.
        begin_frame(3'd6);
        feed(0, TOTAL + 1, -1, 1'b1);
        chk("t7_overrun_err", bus.frame_err, 1);
        tick();
        compare_writes();
        chk("t7_no_done", n_fd - base_fd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
